// File: rtl/uart_pkg.sv
// Shared UART constants and the transmitter state type, reused by the receive path.
// UART_TX_PARITY_EN adds the parity-bit state and the even-parity helper.
package uart_pkg;

    localparam int unsigned CLK_HZ = 100_000_000;
    localparam int unsigned BAUD = 9600;
    // Rounded to the nearest whole cycle: 10416.67 -> 10417.
    localparam int unsigned DEFAULT_CLKS_PER_BIT = (CLK_HZ + BAUD / 2) / BAUD;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_TX_PARITY_EN
        StParity,
`endif
        StStop
    } tx_state_t;

`ifdef UART_TX_PARITY_EN
    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction
`endif

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO for the UART transmitter: registered occupancy, first-word fall-through read.
// DEPTH must be a power of two so the pointers wrap by overflow.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     push_i,
    input  logic [7:0]               wdata_i,
    input  logic                     pop_i,
    output logic [7:0]               rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FullCnt = (AW + 1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == FullCnt);
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata_i;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge CLK) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/uart_tx.sv
// Buffered UART transmitter: 8N1 frames, LSB first, idle-high registered line.
// Define UART_TX_PARITY_EN for 8E1 frames (even parity bit after data bit 7).
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] DATA,
    input  logic       START,
    output logic       FULL,
    output logic       BUSY,
    output logic       OVERRUN,
    output logic       UART_TXD
);

    localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
    localparam int unsigned CNTW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] BaudLast = CW'(CLKS_PER_BIT - 1);

    tx_state_t       state_q, state_d;
    logic [CW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      data_q, data_d;
    logic            txd_q, txd_d;
    logic            busy_q, busy_d;
    logic            overrun_q, overrun_d;

    logic            push, pop, last_tick;
    logic            fifo_full, fifo_empty, fifo_empty_next;
    logic [7:0]      fifo_rdata;
    logic [CNTW-1:0] fifo_count;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .push_i  (push),
        .wdata_i (DATA),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign push      = START & ~fifo_full;
    assign last_tick = (baud_q == BaudLast);

    // Occupancy after this edge, so BUSY tracks the state it is registered alongside.
    assign fifo_empty_next = (fifo_empty & ~push) |
                             ((fifo_count == CNTW'(1)) & pop & ~push);

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q + CW'(1);
        bit_d     = bit_q;
        data_d    = data_q;
        pop       = 1'b0;
        overrun_d = overrun_q | (START & fifo_full);

        case (state_q)
            StIdle: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    data_d  = fifo_rdata;
                    bit_d   = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (last_tick) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = StData;
                end
            end
            StData: begin
                if (last_tick) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (last_tick) begin
                    baud_d  = '0;
                    state_d = StStop;
                end
            end
`endif
            StStop: begin
                if (last_tick) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        data_d  = fifo_rdata;
                        bit_d   = '0;
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                baud_d  = '0;
                state_d = StIdle;
            end
        endcase

        // The line register takes the value belonging to the next cycle's state.
        txd_d = 1'b1;
        case (state_d)
            StStart:  txd_d = 1'b0;
            StData:   txd_d = data_d[bit_d];
`ifdef UART_TX_PARITY_EN
            StParity: txd_d = even_parity(data_d);
`endif
            default:  txd_d = 1'b1;
        endcase

        busy_d = (state_d != StIdle) | ~fifo_empty_next;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StIdle;
            baud_q    <= '0;
            bit_q     <= '0;
            data_q    <= '0;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            data_q    <= data_d;
            txd_q     <= txd_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
        end
    end

    assign FULL     = fifo_full;
    assign BUSY     = busy_q;
    assign OVERRUN  = overrun_q;
    assign UART_TXD = txd_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: a frame-level model predicts accepted bytes and frame start
// cycles, a line monitor decodes frames and checks them; a second default-rate instance times a start bit.
module tb_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int F = NB * CPB;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] DATA = 8'h00;
    logic       START = 1'b0;
    logic       FULL, BUSY, OVERRUN, UART_TXD;

    logic [7:0] data2 = 8'h00;
    logic       start2 = 1'b0;
    logic       full2, busy2, ovr2, txd2;

    always #5 CLK = ~CLK;

    uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .DATA     (DATA),
        .START    (START),
        .FULL     (FULL),
        .BUSY     (BUSY),
        .OVERRUN  (OVERRUN),
        .UART_TXD (UART_TXD)
    );

    uart_tx dut_def (
        .CLK      (CLK),
        .RST      (RST),
        .DATA     (data2),
        .START    (start2),
        .FULL     (full2),
        .BUSY     (busy2),
        .OVERRUN  (ovr2),
        .UART_TXD (txd2)
    );

    typedef struct {
        logic [7:0] b;
        int         start;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] m_q[$];
    int         frame_left = 0;
    bit         m_ovr = 1'b0;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    bit         chk_en = 1'b0;

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, act, req);
        end
    endfunction

    // Frame-level model: a byte queue plus a countdown of cycles left in the current frame.
    initial begin : model
        bit       m_full;
        exp_t     e;
        forever begin
            @(posedge CLK);
            if (RST) begin
                m_q.delete();
                exp_q.delete();
                frame_left = 0;
                m_ovr      = 1'b0;
            end else begin
                m_full = (m_q.size() == DEPTH);
                if (START && m_full) m_ovr = 1'b1;
                if (m_q.size() > 0 && frame_left <= 1) begin
                    e.b     = m_q.pop_front();
                    e.start = cyc + 1;
                    exp_q.push_back(e);
                    frame_left = F;
                end else if (frame_left > 0) begin
                    frame_left--;
                end
                if (START && !m_full) m_q.push_back(DATA);
            end
            cyc++;
        end
    end

    // Status outputs against the model, every cycle.
    initial begin : status_chk
        forever begin
            @(negedge CLK);
            if (chk_en) begin
                check("full", FULL, 64'(m_q.size() == DEPTH));
                check("busy", BUSY, 64'(frame_left > 0 || m_q.size() > 0));
                check("overrun", OVERRUN, 64'(m_ovr));
                if (frame_left == 0) check("idle_line", UART_TXD, 1);
            end
        end
    end

    // Line monitor: decodes each frame and compares it with the next scoreboard entry.
    initial begin : monitor
        exp_t          e;
        bit            have, aborted;
        int            st, nbad;
        logic [7:0]    rx;
        logic [NB-1:0] expv;
        logic          s;
        forever begin
            @(negedge CLK);
            if (chk_en && !RST && UART_TXD === 1'b0) begin
                st   = cyc;
                have = (exp_q.size() > 0);
                if (have) begin
                    e = exp_q.pop_front();
                end else begin
                    e.b     = 8'h00;
                    e.start = -1;
                end
                expv       = '0;
                expv[8:1]  = e.b;
`ifdef UART_TX_PARITY_EN
                expv[9]    = ^e.b;
`endif
                expv[NB-1] = 1'b1;
                aborted = 1'b0;
                nbad    = 0;
                rx      = '0;
                for (int b = 0; b < NB && !aborted; b++) begin
                    for (int k = 0; k < CPB && !aborted; k++) begin
                        if (b != 0 || k != 0) begin
                            @(negedge CLK);
                            if (RST) aborted = 1'b1;
                        end
                        if (!aborted) begin
                            s = UART_TXD;
                            if (s !== expv[b]) nbad++;
                            if (b >= 1 && b <= 8 && k == CPB / 2) rx[b-1] = s;
                        end
                    end
                end
                if (!aborted) begin
                    check("frame_expected", 64'(have), 1);
                    if (have) begin
                        check("frame_start_cycle", 64'(st), 64'(e.start));
                        check("frame_data", rx, e.b);
                        check("frame_bad_cycles", 64'(nbad), 0);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic strobe(input logic [7:0] b);
        START = 1'b1;
        DATA  = b;
        tick();
        START = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            tick();
            done = (frame_left == 0 && m_q.size() == 0 && exp_q.size() == 0);
        end
        check("drain_within_budget", 64'(done), 1);
        idle(2);
    endtask

    initial begin : timeout
        #3_000_000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int n, fall, rise;
        RST = 1'b1;
        idle(3);
        RST    = 1'b0;
        chk_en = 1'b1;
        check("reset_txd", UART_TXD, 1);
        check("reset_busy", BUSY, 0);
        idle(20);

        strobe(8'h55);
        wait_idle(2 * F + 20);

        strobe(8'hA3);
        strobe(8'h0F);
        wait_idle(3 * F + 20);

        for (int i = 1; i <= 6; i++) strobe(8'(i));
        wait_idle(8 * F + 20);
        check("overrun_held", OVERRUN, 1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("overrun_cleared", OVERRUN, 0);

        strobe(8'h07);
        strobe(8'h03);
        wait_idle(3 * F + 20);

        repeat (40) begin
            if ($urandom_range(0, 2) != 0) strobe(8'($urandom));
            else tick();
            idle($urandom_range(0, F + 5));
        end
        wait_idle(12 * F);

        // Reset lands in data bit 3 of 0xFF with bytes still queued.
        strobe(8'hFF);
        strobe(8'h11);
        strobe(8'h22);
        strobe(8'h33);
        idle(15);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("reset_mid_frame_txd", UART_TXD, 1);
        check("reset_mid_frame_busy", BUSY, 0);
        idle(3 * F);
        check("no_frames_after_reset", 64'(exp_q.size()), 0);

        // Default rate: start bit width measured falling to rising edge.
        data2  = 8'h41;
        start2 = 1'b1;
        n      = cyc;
        tick();
        start2 = 1'b0;
        fall   = -1;
        for (int i = 0; i < 20 && fall < 0; i++) begin
            @(negedge CLK);
            if (txd2 === 1'b0) fall = cyc;
        end
        check("default_fall_cycle", 64'(fall), 64'(n + 2));
        rise = -1;
        for (int i = 0; i < 12000 && rise < 0 && fall >= 0; i++) begin
            @(negedge CLK);
            if (txd2 === 1'b1) rise = cyc;
        end
        check("default_start_bit_width", 64'(rise - fall), 10417);
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        idle(5);

        check("scoreboard_empty", 64'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
